// File: rtl/cv32e40n_mem_arb_pkg.sv
// rtl/cv32e40n_mem_arb_pkg.sv - shared types and constants for the data memory arbiter
package cv32e40n_mem_arb_pkg;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_VEC  = 1'b1
  } port_id_e;

  localparam int unsigned OUTST_DEPTH_DEFAULT = 2;

endpackage

// File: rtl/cv32e40n_mem_arb_id_fifo.sv
// rtl/cv32e40n_mem_arb_id_fifo.sv - FIFO of port IDs for granted-but-unanswered transactions
module cv32e40n_mem_arb_id_fifo
  import cv32e40n_mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = OUTST_DEPTH_DEFAULT
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  port_id_e push_id_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output port_id_e head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  port_id_e          mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]     cnt_q, cnt_d;
  logic              push_en, pop_en;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Overflowing pushes and underflowing pops are ignored; pointers wrap naturally (power-of-two depth).
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  // Next-state for pointers and occupancy; push and pop in the same cycle cancel in the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_en && !pop_en) cnt_d = cnt_q + 1'b1;
    if (!push_en && pop_en) cnt_d = cnt_q - 1'b1;
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= push_id_i;
  end

endmodule

// File: rtl/cv32e40n_data_mem_arbiter.sv
// rtl/cv32e40n_data_mem_arbiter.sv - core/vector data port arbiter; round-robin when CV32E40N_DATA_ARB_RR_EN is defined
module cv32e40n_data_mem_arbiter
  import cv32e40n_mem_arb_pkg::*;
#(
  parameter int unsigned OUTST_DEPTH = OUTST_DEPTH_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_master_sel_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  input  logic        vec_req_i,
  input  logic        vec_we_i,
  input  logic [3:0]  vec_be_i,
  input  logic [31:0] vec_addr_i,
  input  logic [31:0] vec_wdata_i,
  output logic        vec_gnt_o,
  output logic        vec_rvalid_o,
  output logic [31:0] vec_rdata_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  output logic        spurious_rvalid_o
);

  logic     win_valid, arb_valid;
  port_id_e win_port;
  logic     lock_q, lock_d;
  port_id_e lock_port_q, lock_port_d;
  logic     fifo_full, fifo_empty, push, pop;
  port_id_e fifo_head;
  logic     locked_req;

`ifdef CV32E40N_DATA_ARB_RR_EN
  port_id_e rr_prio_q, rr_prio_d;
`endif

  assign locked_req = (lock_port_q == PORT_CORE) ? core_req_i : vec_req_i;

  // Winner selection: a stalled request keeps the bus; otherwise ownership, then priority.
  always_comb begin
    win_valid = 1'b0;
    win_port  = PORT_CORE;
    if (lock_q && locked_req) begin
      win_valid = 1'b1;
      win_port  = lock_port_q;
    end else if (mem_master_sel_i) begin
      win_valid = vec_req_i;
      win_port  = PORT_VEC;
    end else if (core_req_i && vec_req_i) begin
      win_valid = 1'b1;
`ifdef CV32E40N_DATA_ARB_RR_EN
      win_port  = rr_prio_q;
`else
      win_port  = PORT_CORE;
`endif
    end else if (core_req_i) begin
      win_valid = 1'b1;
      win_port  = PORT_CORE;
    end else if (vec_req_i) begin
      win_valid = 1'b1;
      win_port  = PORT_VEC;
    end
  end

  // A full ID FIFO blocks issue entirely; a pop this cycle does not free a slot until next cycle.
  assign arb_valid = win_valid & ~fifo_full;
  assign push      = arb_valid & data_gnt_i;
  assign pop       = data_rvalid_i & ~fifo_empty;

  // Shared request mux and grant/response routing.
  always_comb begin
    data_req_o        = 1'b0;
    data_we_o         = 1'b0;
    data_be_o         = '0;
    data_addr_o       = '0;
    data_wdata_o      = '0;
    core_gnt_o        = 1'b0;
    vec_gnt_o         = 1'b0;
    if (arb_valid) begin
      data_req_o = 1'b1;
      if (win_port == PORT_CORE) begin
        data_we_o    = core_we_i;
        data_be_o    = core_be_i;
        data_addr_o  = core_addr_i;
        data_wdata_o = core_wdata_i;
        core_gnt_o   = data_gnt_i;
      end else begin
        data_we_o    = vec_we_i;
        data_be_o    = vec_be_i;
        data_addr_o  = vec_addr_i;
        data_wdata_o = vec_wdata_i;
        vec_gnt_o    = data_gnt_i;
      end
    end
  end

  assign core_rvalid_o     = pop & (fifo_head == PORT_CORE);
  assign vec_rvalid_o      = pop & (fifo_head == PORT_VEC);
  assign core_rdata_o      = data_rdata_i;
  assign vec_rdata_o       = data_rdata_i;
  assign spurious_rvalid_o = data_rvalid_i & fifo_empty;

  assign lock_d      = arb_valid & ~data_gnt_i;
  assign lock_port_d = win_port;

  // Lock register: remembers a presented-but-ungranted winner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q      <= 1'b0;
      lock_port_q <= PORT_CORE;
    end else begin
      lock_q      <= lock_d;
      lock_port_q <= lock_port_d;
    end
  end

`ifdef CV32E40N_DATA_ARB_RR_EN
  assign rr_prio_d = push ? ((win_port == PORT_CORE) ? PORT_VEC : PORT_CORE) : rr_prio_q;

  // Round-robin pointer: priority goes to the port not granted most recently.
  always_ff @(posedge clk_i) begin
    if (rst_i) rr_prio_q <= PORT_CORE;
    else       rr_prio_q <= rr_prio_d;
  end
`endif

  cv32e40n_mem_arb_id_fifo #(
    .DEPTH(OUTST_DEPTH)
  ) u_id_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (push),
    .push_id_i(win_port),
    .pop_i    (pop),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .head_o   (fifo_head)
  );

endmodule

// File: tb/tb_cv32e40n_data_mem_arbiter.sv
// tb/tb_cv32e40n_data_mem_arbiter.sv - scoreboard bench for the data memory arbiter
module tb_cv32e40n_data_mem_arbiter;

  logic        clk, rst_i, mem_master_sel_i;
  logic        core_req_i, core_we_i, vec_req_i, vec_we_i;
  logic [3:0]  core_be_i, vec_be_i;
  logic [31:0] core_addr_i, core_wdata_i, vec_addr_i, vec_wdata_i;
  logic        core_gnt_o, core_rvalid_o, vec_gnt_o, vec_rvalid_o;
  logic [31:0] core_rdata_o, vec_rdata_o;
  logic        data_req_o, data_we_o, data_gnt_i, data_rvalid_i, spurious_rvalid_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   model_q[$];
  int   checks = 0;
  int   errors = 0;

  cv32e40n_data_mem_arbiter #(.OUTST_DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .mem_master_sel_i(mem_master_sel_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .vec_req_i(vec_req_i), .vec_we_i(vec_we_i), .vec_be_i(vec_be_i),
    .vec_addr_i(vec_addr_i), .vec_wdata_i(vec_wdata_i),
    .vec_gnt_o(vec_gnt_o), .vec_rvalid_o(vec_rvalid_o), .vec_rdata_o(vec_rdata_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .spurious_rvalid_o(spurious_rvalid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clear_inputs();
    mem_master_sel_i = 1'b0;
    core_req_i = 1'b0; core_we_i = 1'b0; core_be_i = 4'h0; core_addr_i = '0; core_wdata_i = '0;
    vec_req_i  = 1'b0; vec_we_i  = 1'b0; vec_be_i  = 4'h0; vec_addr_i  = '0; vec_wdata_i  = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
  endtask

  // Issue a memory response; expected port comes from the bench's own outstanding model.
  task automatic rv(input logic [31:0] d);
    exp_t e;
    data_rvalid_i = 1'b1;
    data_rdata_i  = d;
    e.data = d;
    if (model_q.size() > 0) e.kind = model_q.pop_front();
    else                    e.kind = 2;
    sb_q.push_back(e);
  endtask

  task automatic gnt_note(input int p);
    model_q.push_back(p);
  endtask

  // Monitor: compares every response-side event against the scoreboard head.
  always @(negedge clk) begin
    int   n, kind;
    exp_t e;
    if (!rst_i && (core_rvalid_o || vec_rvalid_o || spurious_rvalid_o)) begin
      n = int'(core_rvalid_o) + int'(vec_rvalid_o) + int'(spurious_rvalid_o);
      kind = (n > 1) ? 3 : spurious_rvalid_o ? 2 : vec_rvalid_o ? 1 : 0;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got kind %0d, expected no response", kind);
      end else begin
        e = sb_q.pop_front();
        if (kind != e.kind) begin
          errors++;
          $display("FAIL sb_kind: got %0d expected %0d", kind, e.kind);
        end else if (kind == 0 && core_rdata_o !== e.data) begin
          errors++;
          $display("FAIL sb_core_rdata: got %h expected %h", core_rdata_o, e.data);
        end else if (kind == 1 && vec_rdata_o !== e.data) begin
          errors++;
          $display("FAIL sb_vec_rdata: got %h expected %h", vec_rdata_o, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_w;
    clear_inputs();
    rst_i = 1'b1;
    tick(); tick();
    settle();
    chk("rst_data_req", data_req_o, 0);
    chk("rst_core_gnt", core_gnt_o, 0);
    chk("rst_vec_gnt", vec_gnt_o, 0);
    chk("rst_spurious", spurious_rvalid_o, 0);
    chk("rst_rvalids", {core_rvalid_o, vec_rvalid_o}, 0);
    tick();
    rst_i = 1'b0;
    tick();

    // Core read with immediate grant and next-cycle response
    core_req_i = 1'b1; core_be_i = 4'hF; core_addr_i = 32'h100; data_gnt_i = 1'b1;
    gnt_note(0);
    settle();
    chk("t1_req", data_req_o, 1);
    chk("t1_addr", data_addr_o, 32'h100);
    chk("t1_core_gnt", core_gnt_o, 1);
    chk("t1_vec_gnt", vec_gnt_o, 0);
    tick();
    clear_inputs();
    rv(32'hDEADBEEF);
    settle();
    chk("t1_core_rvalid", core_rvalid_o, 1);
    chk("t1_core_rdata", core_rdata_o, 32'hDEADBEEF);
    chk("t1_vec_rvalid", vec_rvalid_o, 0);
    tick();
    clear_inputs();

    // Vector ownership: only port 1 is served, simultaneous push/pop keeps throughput
    mem_master_sel_i = 1'b1;
    core_req_i = 1'b1; core_addr_i = 32'h200;
    vec_req_i = 1'b1; vec_we_i = 1'b1; vec_be_i = 4'h3; vec_addr_i = 32'h300; vec_wdata_i = 32'h55;
    data_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) rv(32'hA000_0000 + i);
      gnt_note(1);
      settle();
      chk("t2_vec_gnt", vec_gnt_o, 1);
      chk("t2_core_gnt", core_gnt_o, 0);
      chk("t2_addr", data_addr_o, 32'h300);
      chk("t2_we_be_wdata", {data_we_o, data_be_o, data_wdata_o}, {1'b1, 4'h3, 32'h55});
      tick();
      data_rvalid_i = 1'b0;
    end
    clear_inputs();
    rv(32'hA000_0003);
    tick();
    clear_inputs();

    // Lock: stalled vector request holds the bus while core requests
    vec_req_i = 1'b1; vec_addr_i = 32'h400;
    settle();
    chk("t3_req", data_req_o, 1);
    chk("t3_addr0", data_addr_o, 32'h400);
    tick();
    core_req_i = 1'b1; core_addr_i = 32'h500;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("t3_addr_locked", data_addr_o, 32'h400);
      chk("t3_gnts_low", {core_gnt_o, vec_gnt_o}, 0);
      tick();
    end
    data_gnt_i = 1'b1;
    gnt_note(1);
    settle();
    chk("t3_addr_gnt", data_addr_o, 32'h400);
    chk("t3_vec_gnt", vec_gnt_o, 1);
    tick();
    vec_req_i = 1'b0;
    gnt_note(0);
    settle();
    chk("t3_core_addr", data_addr_o, 32'h500);
    chk("t3_core_gnt", core_gnt_o, 1);
    tick();

    // FIFO full: issue blocked until a response, no same-cycle bypass
    core_addr_i = 32'h600;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("t4_full_req", data_req_o, 0);
      chk("t4_full_gnt", core_gnt_o, 0);
      tick();
    end
    rv(32'hB000_0001);
    settle();
    chk("t4_nobypass_req", data_req_o, 0);
    chk("t4_vec_rvalid", vec_rvalid_o, 1);
    tick();
    data_rvalid_i = 1'b0;
    gnt_note(0);
    settle();
    chk("t4_req_after", data_req_o, 1);
    chk("t4_core_gnt_after", core_gnt_o, 1);
    chk("t4_addr_after", data_addr_o, 32'h600);
    tick();
    clear_inputs();
    rv(32'hB000_0002);
    tick();
    rv(32'hB000_0003);
    settle();
    chk("t4_core_rvalid", core_rvalid_o, 1);
    tick();
    clear_inputs();

    // Spurious response with nothing outstanding
    rv(32'hC000_0000);
    settle();
    chk("t5_spurious", spurious_rvalid_o, 1);
    chk("t5_rvalids", {core_rvalid_o, vec_rvalid_o}, 0);
    tick();
    clear_inputs();
    settle();
    chk("t5_spurious_pulse", spurious_rvalid_o, 0);
    tick();
    core_req_i = 1'b1; core_addr_i = 32'h700; data_gnt_i = 1'b1;
    gnt_note(0);
    tick();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    model_q.delete();
    settle();
    chk("t5_post_rst_req", data_req_o, 0);
    tick();
    rv(32'hC000_0001);
    settle();
    chk("t5_stale_spurious", spurious_rvalid_o, 1);
    chk("t5_stale_core_rvalid", core_rvalid_o, 0);
    tick();
    clear_inputs();

    // Both ports requesting with immediate grants
    core_req_i = 1'b1; core_addr_i = 32'h800;
    vec_req_i = 1'b1; vec_addr_i = 32'h900;
    data_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef CV32E40N_DATA_ARB_RR_EN
      exp_w = i % 2;
`else
      exp_w = 0;
`endif
      if (i > 0) rv(32'hD000_0000 + i);
      gnt_note(exp_w);
      settle();
      chk("t6_core_gnt", core_gnt_o, (exp_w == 0) ? 1 : 0);
      chk("t6_vec_gnt", vec_gnt_o, (exp_w == 1) ? 1 : 0);
      chk("t6_addr", data_addr_o, (exp_w == 1) ? 32'h900 : 32'h800);
      tick();
      data_rvalid_i = 1'b0;
    end
    clear_inputs();
    rv(32'hD000_0004);
    tick();
    clear_inputs();
    tick();

    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cv32e40n_data_mem_arbiter.md
CV32E40N_DATA_MEM_ARBITER -- requirements
Module: cv32e40n_data_mem_arbiter

Interface
REQ-001 Parameter OUTST_DEPTH, default 2: max outstanding granted-but-unanswered memory transactions (power of two, >=2).
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 mem_master_sel_i  in  1  vector-unit exclusive-access request, from APU-side responder.
REQ-005 core_req_i/core_we_i/core_be_i/core_addr_i/core_wdata_i  in  1/1/4/32/32  core LSU request (port 0).
REQ-006 core_gnt_o/core_rvalid_o/core_rdata_o  out  1/1/32  core LSU response (port 0).
REQ-007 vec_req_i/vec_we_i/vec_be_i/vec_addr_i/vec_wdata_i  in  1/1/4/32/32  vector-unit request (port 1).
REQ-008 vec_gnt_o/vec_rvalid_o/vec_rdata_o  out  1/1/32  vector-unit response (port 1).
REQ-009 data_req_o/data_we_o/data_be_o/data_addr_o/data_wdata_o  out  1/1/4/32/32  shared memory request.
REQ-010 data_gnt_i/data_rvalid_i/data_rdata_i  in  1/1/32  shared memory response.
REQ-011 spurious_rvalid_o  out  1  one-cycle pulse: data_rvalid_i with no outstanding transaction.

Function
REQ-012 Winner selection is combinational; data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o SHALL mirror the winner's request fields in the same cycle (zero when no winner).
REQ-013 mem_master_sel_i=1: only port 1 SHALL be eligible; core_gnt_o SHALL stay 0.
REQ-014 mem_master_sel_i=0, both requesting, macro absent: port 0 SHALL win.
REQ-015 Lock: if data_req_o=1 and data_gnt_i=0, the same port SHALL stay selected next cycle regardless of other requests or mem_master_sel_i, until granted or its req drops.
REQ-016 Grant: data_gnt_i SHALL be routed only to the winner's gnt output, same cycle.
REQ-017 On data_req_o & data_gnt_i, winner port ID SHALL be pushed into the outstanding-ID FIFO.
REQ-018 FIFO full: data_req_o SHALL be 0 and both gnt outputs 0; no same-cycle pop bypass.
REQ-019 On data_rvalid_i with FIFO non-empty: head popped; matching port's rvalid driven 1 same cycle; data_rdata_i driven to both rdata outputs unconditionally.
REQ-020 On data_rvalid_i with FIFO empty: spurious_rvalid_o=1 that cycle, both rvalid outputs 0, FIFO unchanged.
REQ-021 Simultaneous push and pop (not full) SHALL both take effect; occupancy unchanged.
REQ-022 FIFO pointers SHALL wrap modulo OUTST_DEPTH; occupancy counter width clog2(OUTST_DEPTH)+1.
REQ-023 Responses SHALL return in grant order (in-order memory assumed).

Reset
REQ-024 While rst_i=1 at a clock edge: FIFO emptied, lock cleared, round-robin pointer set to port 0.
REQ-025 Post-reset outputs: all gnt/rvalid 0, data_req_o 0, spurious_rvalid_o 0 unless data_rvalid_i=1.
REQ-026 Reset mid-transaction SHALL discard outstanding IDs; later stale rvalids SHALL be reported spurious.

Configuration
REQ-027 Macro CV32E40N_DATA_ARB_RR_EN defined: with mem_master_sel_i=0 and both requesting, winner SHALL be the port not granted most recently (pointer updated on each grant).
REQ-028 Macro undefined: fixed priority per REQ-014; no round-robin state present.

Structure
REQ-029 Package cv32e40n_mem_arb_pkg SHALL hold port-ID typedef (PORT_CORE=0, PORT_VEC=1) and OUTST_DEPTH default constant.
REQ-030 Outstanding-ID FIFO SHALL be sub-module cv32e40n_mem_arb_id_fifo (push, pop, full, empty, head).

Verification
REQ-031 Core read 0x100, gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF -> core_gnt_o=1, then core_rvalid_o=1, core_rdata_o=0xDEADBEEF, vec_rvalid_o=0.
REQ-032 mem_master_sel_i=1, both req -> only vec granted; core_gnt_o=0 for all cycles sel stays 1.
REQ-033 Vec req, data_gnt_i=0 for 3 cycles while core asserts req -> data_addr_o stays vec address until grant.
REQ-034 Two grants without rvalid (OUTST_DEPTH=2), third request -> data_req_o=0 until one rvalid, then granted next cycle.
REQ-035 data_rvalid_i with no outstanding -> spurious_rvalid_o=1 one cycle, no port rvalid; reset with 1 outstanding then rvalid -> spurious.
REQ-036 Macro defined, both ports requesting continuously with immediate gnt -> grants alternate 0,1,0,1.
